// File: rtl/ysyx_22051013_lsu_pkg.sv
// Shared definitions for the load/store stage: data widths, instruction
// select codes and access-size decode helpers.
package ysyx_22051013_lsu_pkg;

    localparam int DATA_W = 64;
    localparam int REG_W  = 64;
    localparam int PC_W   = 64;

    // Instruction select codes driven by the execute stage.
    localparam logic [7:0] INST_NOP = 8'h00;
    localparam logic [7:0] INST_ADD = 8'h01;
    localparam logic [7:0] INST_SUB = 8'h02;
    localparam logic [7:0] INST_AND = 8'h03;
    localparam logic [7:0] INST_OR  = 8'h04;
    localparam logic [7:0] INST_XOR = 8'h05;
    localparam logic [7:0] INST_LB  = 8'h20;
    localparam logic [7:0] INST_LH  = 8'h21;
    localparam logic [7:0] INST_LW  = 8'h22;
    localparam logic [7:0] INST_LD  = 8'h23;
    localparam logic [7:0] INST_LBU = 8'h24;
    localparam logic [7:0] INST_LHU = 8'h25;
    localparam logic [7:0] INST_LWU = 8'h26;
    localparam logic [7:0] INST_SB  = 8'h28;
    localparam logic [7:0] INST_SH  = 8'h29;
    localparam logic [7:0] INST_SW  = 8'h2A;
    localparam logic [7:0] INST_SD  = 8'h2B;

    typedef enum logic [1:0] {
        SZ_B = 2'd0,
        SZ_H = 2'd1,
        SZ_W = 2'd2,
        SZ_D = 2'd3
    } acc_size_e;

    function automatic logic f_is_load(input logic [7:0] sel);
        return sel inside {INST_LB, INST_LH, INST_LW, INST_LD,
                           INST_LBU, INST_LHU, INST_LWU};
    endfunction

    function automatic logic f_is_store(input logic [7:0] sel);
        return sel inside {INST_SB, INST_SH, INST_SW, INST_SD};
    endfunction

    // Non-memory codes fall into SZ_D; callers qualify with load/store.
    function automatic acc_size_e f_acc_size(input logic [7:0] sel);
        acc_size_e sz;
        case (sel)
            INST_LB, INST_LBU, INST_SB: sz = SZ_B;
            INST_LH, INST_LHU, INST_SH: sz = SZ_H;
            INST_LW, INST_LWU, INST_SW: sz = SZ_W;
            default:                    sz = SZ_D;
        endcase
        return sz;
    endfunction

endpackage

// File: rtl/ysyx_22051013_lsu_align.sv
// Combinational access decode: load/store classification, alignment check,
// store lane shifting with byte mask, and load data extraction/extension.
module ysyx_22051013_lsu_align
    import ysyx_22051013_lsu_pkg::*;
(
    input  logic [7:0]  i_sel,
    input  logic [2:0]  i_off,
    input  logic [63:0] i_sdata,
    input  logic [63:0] i_rdata,
    output logic        o_is_load,
    output logic        o_is_store,
    output logic        o_misalign,
    output logic [7:0]  o_wmask,
    output logic [63:0] o_wdata,
    output logic [63:0] o_ldata
);

    acc_size_e   w_size;
    logic [63:0] w_rsh;

    assign o_is_load  = f_is_load(i_sel);
    assign o_is_store = f_is_store(i_sel);
    assign w_size     = f_acc_size(i_sel);
    assign o_wdata    = i_sdata << {i_off, 3'b000};
    assign w_rsh      = i_rdata >> {i_off, 3'b000};

    // Natural-alignment check, only meaningful for memory ops
    always_comb begin
        o_misalign = 1'b0;
        if (o_is_load || o_is_store) begin
            case (w_size)
                SZ_B:    o_misalign = 1'b0;
                SZ_H:    o_misalign = i_off[0];
                SZ_W:    o_misalign = (i_off[1:0] != 2'b00);
                default: o_misalign = (i_off != 3'b000);
            endcase
        end
    end

    // Byte-enable mask for stores; loads never write
    always_comb begin
        o_wmask = 8'h00;
        if (o_is_store) begin
            case (w_size)
                SZ_B:    o_wmask = 8'h01 << i_off;
                SZ_H:    o_wmask = 8'h03 << i_off;
                SZ_W:    o_wmask = 8'h0F << i_off;
                default: o_wmask = 8'hFF;
            endcase
        end
    end

    // Pick the addressed lane out of the shifted doubleword and extend it
    always_comb begin
        case (i_sel)
            INST_LB:  o_ldata = {{56{w_rsh[7]}},  w_rsh[7:0]};
            INST_LH:  o_ldata = {{48{w_rsh[15]}}, w_rsh[15:0]};
            INST_LW:  o_ldata = {{32{w_rsh[31]}}, w_rsh[31:0]};
            INST_LBU: o_ldata = {56'd0, w_rsh[7:0]};
            INST_LHU: o_ldata = {48'd0, w_rsh[15:0]};
            INST_LWU: o_ldata = {32'd0, w_rsh[31:0]};
            INST_LD:  o_ldata = w_rsh;
            default:  o_ldata = 64'd0;
        endcase
    end

endmodule

// File: rtl/ysyx_22051013_lsu.sv
// Load/store pipeline stage: registers the execute result, runs one
// req/gnt/rvalid memory transaction per memory op and presents the
// result to write-back under valid/ready.
//
// state  | meaning
// IDLE   | empty, ready to accept
// REQ    | mem_req asserted, waiting for mem_gnt
// WAIT   | load granted, waiting for mem_rvalid
// DONE   | result valid for write-back
module ysyx_22051013_lsu
    import ysyx_22051013_lsu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        ex_valid,
    output logic        ls_ready,
    input  logic [7:0]  alu_sel,
    input  logic [63:0] exu_res,
    input  logic [63:0] store_data,
    input  logic [4:0]  rd_addr,
    input  logic        rd_wen,
    input  logic        wb_ready,
    output logic        ls_valid,
    output logic [63:0] ls_res,
    output logic [4:0]  ls_rd_addr,
    output logic        ls_rd_wen,
    output logic        ls_misalign,
    output logic        mem_req,
    output logic        mem_we,
    output logic [63:0] mem_addr,
    output logic [63:0] mem_wdata,
    output logic [7:0]  mem_wmask,
    input  logic        mem_gnt,
    input  logic        mem_rvalid,
    input  logic [63:0] mem_rdata
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_WAIT = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]  r_state;
    logic [1:0]  w_state_nxt;
    logic [7:0]  r_sel;
    logic [63:0] r_addr;
    logic [63:0] r_sdata;
    logic [63:0] r_res;
    logic [4:0]  r_rd_addr;
    logic        r_rd_wen;
    logic        r_misalign;

    logic        w_use_in;
    logic        w_accept;
    logic [7:0]  w_sel;
    logic [2:0]  w_off;
    logic [63:0] w_sdata;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_misalign;
    logic [7:0]  w_wmask;
    logic [63:0] w_wdata;
    logic [63:0] w_ldata;

    // The decoder sees the incoming instruction in states that can accept,
    // and the registered one while a memory transaction is in flight.
    assign w_use_in = (r_state == S_IDLE) || (r_state == S_DONE);
    assign w_sel    = w_use_in ? alu_sel        : r_sel;
    assign w_off    = w_use_in ? exu_res[2:0]   : r_addr[2:0];
    assign w_sdata  = w_use_in ? store_data     : r_sdata;

    assign ls_ready = (r_state == S_IDLE) || ((r_state == S_DONE) && wb_ready);
    assign w_accept = ex_valid && ls_ready;

    ysyx_22051013_lsu_align u_align (
        .i_sel      (w_sel),
        .i_off      (w_off),
        .i_sdata    (w_sdata),
        .i_rdata    (mem_rdata),
        .o_is_load  (w_is_load),
        .o_is_store (w_is_store),
        .o_misalign (w_misalign),
        .o_wmask    (w_wmask),
        .o_wdata    (w_wdata),
        .o_ldata    (w_ldata)
    );

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (w_accept) begin
                    w_state_nxt = ((w_is_load || w_is_store) && !w_misalign) ? S_REQ : S_DONE;
                end else if ((r_state == S_DONE) && wb_ready) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_REQ: begin
                if (mem_gnt) begin
                    w_state_nxt = w_is_store ? S_DONE : S_WAIT;
                end
            end
            S_WAIT: begin
                if (mem_rvalid) begin
                    w_state_nxt = S_DONE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State, captured instruction fields and result register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_sel      <= INST_NOP;
            r_addr     <= 64'd0;
            r_sdata    <= 64'd0;
            r_res      <= 64'd0;
            r_rd_addr  <= 5'd0;
            r_rd_wen   <= 1'b0;
            r_misalign <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_sel      <= alu_sel;
                r_addr     <= exu_res;
                r_sdata    <= store_data;
                r_rd_addr  <= rd_addr;
                r_rd_wen   <= rd_wen && !w_misalign;
                r_misalign <= w_misalign;
                r_res      <= w_misalign ? 64'd0 : exu_res;
            end else if ((r_state == S_WAIT) && mem_rvalid) begin
                r_res <= w_ldata;
            end
        end
    end

    assign ls_valid    = (r_state == S_DONE);
    assign ls_res      = r_res;
    assign ls_rd_addr  = r_rd_addr;
    assign ls_rd_wen   = r_rd_wen;
    assign ls_misalign = r_misalign;

    // Request fields come only from state and registered fields, so they
    // hold steady across gnt stalls.
    assign mem_req   = (r_state == S_REQ);
    assign mem_we    = mem_req && w_is_store;
    assign mem_addr  = {r_addr[63:3], 3'b000};
    assign mem_wdata = mem_req ? w_wdata : 64'd0;
    assign mem_wmask = mem_req ? w_wmask : 8'h00;

endmodule

// File: tb/tb_ysyx_22051013_lsu.sv
// Directed bench for the load/store stage with hand-computed expectations.
module tb_ysyx_22051013_lsu;
    import ysyx_22051013_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid;
    logic        ls_ready;
    logic [7:0]  alu_sel;
    logic [63:0] exu_res;
    logic [63:0] store_data;
    logic [4:0]  rd_addr;
    logic        rd_wen;
    logic        wb_ready;
    logic        ls_valid;
    logic [63:0] ls_res;
    logic [4:0]  ls_rd_addr;
    logic        ls_rd_wen;
    logic        ls_misalign;
    logic        mem_req;
    logic        mem_we;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;

    int n_chk  = 0;
    int n_pass = 0;
    int n_unstable = 0;

    logic [63:0] cap_addr;
    logic [63:0] cap_wdata;
    logic [7:0]  cap_wmask;
    logic        cap_we;

    localparam logic [63:0] RD_PAT = 64'hF123_4567_89AB_CDEF;

    typedef struct {
        logic [7:0]  sel;
        logic [63:0] addr;
        logic [63:0] exp;
    } ld_t;
    ld_t ld_tab[5];

    always #5 clk = ~clk;

    ysyx_22051013_lsu dut (
        .clk         (clk),
        .rst         (rst),
        .ex_valid    (ex_valid),
        .ls_ready    (ls_ready),
        .alu_sel     (alu_sel),
        .exu_res     (exu_res),
        .store_data  (store_data),
        .rd_addr     (rd_addr),
        .rd_wen      (rd_wen),
        .wb_ready    (wb_ready),
        .ls_valid    (ls_valid),
        .ls_res      (ls_res),
        .ls_rd_addr  (ls_rd_addr),
        .ls_rd_wen   (ls_rd_wen),
        .ls_misalign (ls_misalign),
        .mem_req     (mem_req),
        .mem_we      (mem_we),
        .mem_addr    (mem_addr),
        .mem_wdata   (mem_wdata),
        .mem_wmask   (mem_wmask),
        .mem_gnt     (mem_gnt),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %h expected %h", tag, obs, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Issue one instruction and play the memory side; returns the number of
    // cycles mem_req was seen and the cycle (after accept) ls_valid rose.
    task automatic run_mem(input logic [7:0] sel, input logic [63:0] addr,
                           input logic [63:0] sdata, input logic [63:0] rdata,
                           input int gnt_dly, input int rv_dly,
                           output int req_cyc, output int lat);
        int  wcyc;
        bit  granted;
        bit  done;
        ex_valid   = 1'b1;
        alu_sel    = sel;
        exu_res    = addr;
        store_data = sdata;
        rd_addr    = 5'd9;
        rd_wen     = 1'b1;
        mem_rdata  = rdata;
        mem_gnt    = 1'b0;
        mem_rvalid = 1'b0;
        step();
        ex_valid = 1'b0;
        req_cyc = 0; lat = 0; wcyc = 0; granted = 0; done = 0;
        for (int k = 1; k <= 40 && !done; k++) begin
            @(negedge clk);
            mem_gnt    = 1'b0;
            mem_rvalid = 1'b0;
            if (ls_valid) begin
                lat  = k;
                done = 1;
            end else if (mem_req) begin
                req_cyc++;
                if (req_cyc == 1) begin
                    cap_addr = mem_addr; cap_wdata = mem_wdata;
                    cap_wmask = mem_wmask; cap_we = mem_we;
                end else if (mem_addr !== cap_addr || mem_wdata !== cap_wdata ||
                             mem_wmask !== cap_wmask || mem_we !== cap_we) begin
                    n_unstable++;
                end
                if (req_cyc > gnt_dly) begin
                    mem_gnt = 1'b1;
                    granted = 1;
                end
            end else if (granted) begin
                wcyc++;
                if (wcyc > rv_dly) mem_rvalid = 1'b1;
            end
        end
        if (!done) chk("mem_timeout", 64'd0, 64'd1);
    endtask

    initial begin
        int rc;
        int lat;

        ld_tab[0] = '{INST_LH,  64'h8000_0106, 64'hFFFF_FFFF_FFFF_F123};
        ld_tab[1] = '{INST_LHU, 64'h8000_0102, 64'h0000_0000_0000_89AB};
        ld_tab[2] = '{INST_LW,  64'h8000_0104, 64'hFFFF_FFFF_F123_4567};
        ld_tab[3] = '{INST_LWU, 64'h8000_0100, 64'h0000_0000_89AB_CDEF};
        ld_tab[4] = '{INST_LB,  64'h8000_0101, 64'hFFFF_FFFF_FFFF_FFCD};

        rst = 1'b0; ex_valid = 1'b0; alu_sel = INST_NOP; exu_res = '0;
        store_data = '0; rd_addr = '0; rd_wen = 1'b0; wb_ready = 1'b1;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;

        // reset values
        step(); step();
        @(negedge clk);
        chk("rst_ls_ready",  64'(ls_ready),    64'd1);
        chk("rst_ls_valid",  64'(ls_valid),    64'd0);
        chk("rst_ls_res",    ls_res,           64'd0);
        chk("rst_rd_addr",   64'(ls_rd_addr),  64'd0);
        chk("rst_rd_wen",    64'(ls_rd_wen),   64'd0);
        chk("rst_misalign",  64'(ls_misalign), 64'd0);
        chk("rst_mem_req",   64'(mem_req),     64'd0);
        chk("rst_mem_we",    64'(mem_we),      64'd0);
        chk("rst_mem_addr",  mem_addr,         64'd0);
        chk("rst_mem_wdata", mem_wdata,        64'd0);
        chk("rst_mem_wmask", 64'(mem_wmask),   64'd0);
        step();
        rst = 1'b1;
        step();

        // back-to-back non-memory ops
        ex_valid = 1'b1; alu_sel = INST_ADD; exu_res = 64'h1234; rd_addr = 5'd5; rd_wen = 1'b1;
        step();
        exu_res = 64'h5678; rd_addr = 5'd6;
        @(negedge clk);
        chk("add0_valid",   64'(ls_valid),    64'd1);
        chk("add0_res",     ls_res,           64'h1234);
        chk("add0_rd_addr", 64'(ls_rd_addr),  64'd5);
        chk("add0_rd_wen",  64'(ls_rd_wen),   64'd1);
        chk("add0_mem_req", 64'(mem_req),     64'd0);
        chk("add0_ready",   64'(ls_ready),    64'd1);
        step();
        ex_valid = 1'b0;
        @(negedge clk);
        chk("add1_valid",   64'(ls_valid),    64'd1);
        chk("add1_res",     ls_res,           64'h5678);
        chk("add1_rd_addr", 64'(ls_rd_addr),  64'd6);
        step();
        @(negedge clk);
        chk("add_idle_valid", 64'(ls_valid), 64'd0);

        // SB at offset 5
        run_mem(INST_SB, 64'h8000_0005, 64'hAB, 64'd0, 0, 0, rc, lat);
        chk("sb_addr",  cap_addr,        64'h8000_0000);
        chk("sb_wmask", 64'(cap_wmask),  64'h20);
        chk("sb_wdata", cap_wdata,       64'h0000_AB00_0000_0000);
        chk("sb_we",    64'(cap_we),     64'd1);
        chk("sb_req",   64'(rc),         64'd1);
        chk("sb_lat",   64'(lat),        64'd2);
        chk("sb_res",   ls_res,          64'h8000_0005);
        chk("sb_rdwen", 64'(ls_rd_wen),  64'd1);

        // SH at offset 2, gnt one cycle late (accepted straight from DONE)
        run_mem(INST_SH, 64'h8000_1002, 64'h1234_BEEF, 64'd0, 1, 0, rc, lat);
        chk("sh_wmask", 64'(cap_wmask), 64'h0C);
        chk("sh_wdata", cap_wdata,      64'h0000_1234_BEEF_0000);
        chk("sh_req",   64'(rc),        64'd2);
        chk("sh_lat",   64'(lat),       64'd3);

        run_mem(INST_SW, 64'h8000_2004, 64'h1122_3344, 64'd0, 0, 0, rc, lat);
        chk("sw_wmask", 64'(cap_wmask), 64'hF0);
        chk("sw_wdata", cap_wdata,      64'h1122_3344_0000_0000);
        chk("sw_addr",  cap_addr,       64'h8000_2000);

        run_mem(INST_SD, 64'h8000_3008, 64'hDEAD_BEEF_0123_4567, 64'd0, 0, 0, rc, lat);
        chk("sd_wmask", 64'(cap_wmask), 64'hFF);
        chk("sd_wdata", cap_wdata,      64'hDEAD_BEEF_0123_4567);

        // LB / LBU at offset 3 with gnt two cycles late
        run_mem(INST_LB, 64'h8000_0003, 64'h0000_0000_8000_0000, 64'h0000_0000_8000_0000, 2, 0, rc, lat);
        chk("lb_res",   ls_res,         64'hFFFF_FFFF_FFFF_FF80);
        chk("lb_req",   64'(rc),        64'd3);
        chk("lb_lat",   64'(lat),       64'd5);
        chk("lb_we",    64'(cap_we),    64'd0);
        chk("lb_wmask", 64'(cap_wmask), 64'd0);
        chk("lb_addr",  cap_addr,       64'h8000_0000);
        run_mem(INST_LBU, 64'h8000_0003, 64'd0, 64'h0000_0000_8000_0000, 2, 0, rc, lat);
        chk("lbu_res", ls_res,  64'h80);
        chk("lbu_req", 64'(rc), 64'd3);

        // load extension table, alternating rvalid delay
        for (int i = 0; i < 5; i++) begin
            run_mem(ld_tab[i].sel, ld_tab[i].addr, 64'd0, RD_PAT, 0, i % 2, rc, lat);
            chk($sformatf("ld%0d_res", i), ls_res,   ld_tab[i].exp);
            chk($sformatf("ld%0d_lat", i), 64'(lat), 64'(3 + (i % 2)));
            chk($sformatf("ld%0d_rd",  i), 64'(ls_rd_addr), 64'd9);
        end

        // misaligned accesses: no request, result forced to zero
        run_mem(INST_LW, 64'h8000_0002, 64'd0, RD_PAT, 0, 0, rc, lat);
        chk("lw_mis_flag",  64'(ls_misalign), 64'd1);
        chk("lw_mis_rdwen", 64'(ls_rd_wen),   64'd0);
        chk("lw_mis_res",   ls_res,           64'd0);
        chk("lw_mis_req",   64'(rc),          64'd0);
        chk("lw_mis_lat",   64'(lat),         64'd1);
        run_mem(INST_SH, 64'h8000_0001, 64'hFFFF, 64'd0, 0, 0, rc, lat);
        chk("sh_mis_flag", 64'(ls_misalign), 64'd1);
        chk("sh_mis_req",  64'(rc),          64'd0);
        run_mem(INST_SD, 64'h8000_0004, 64'hFFFF, 64'd0, 0, 0, rc, lat);
        chk("sd_mis_flag", 64'(ls_misalign), 64'd1);
        chk("sd_mis_res",  ls_res,           64'd0);

        // LD with write-back stalled for four cycles
        step();
        wb_ready = 1'b0;
        run_mem(INST_LD, 64'h8000_0040, 64'd0, RD_PAT, 0, 0, rc, lat);
        chk("ld_lat",      64'(lat),         64'd3);
        chk("ld_res",      ls_res,           RD_PAT);
        chk("ld_misalign", 64'(ls_misalign), 64'd0);
        chk("ld_ready",    64'(ls_ready),    64'd0);
        ex_valid = 1'b1; alu_sel = INST_ADD; exu_res = 64'h99; rd_addr = 5'd3;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("ld_hold%0d_valid", i), 64'(ls_valid), 64'd1);
            chk($sformatf("ld_hold%0d_res",   i), ls_res,         RD_PAT);
            chk($sformatf("ld_hold%0d_ready", i), 64'(ls_ready), 64'd0);
        end
        wb_ready = 1'b1;
        #1;
        chk("ld_release_ready", 64'(ls_ready), 64'd1);
        step();
        ex_valid = 1'b0;
        @(negedge clk);
        chk("after_ld_valid", 64'(ls_valid), 64'd1);
        chk("after_ld_res",   ls_res,        64'h99);
        step();

        // reset while in REQ drops the request at once
        ex_valid = 1'b1; alu_sel = INST_SW; exu_res = 64'h8000_0200; store_data = 64'h1;
        step();
        ex_valid = 1'b0;
        @(negedge clk);
        chk("rreq_req_before", 64'(mem_req), 64'd1);
        rst = 1'b0;
        #1;
        chk("rreq_req_after", 64'(mem_req), 64'd0);
        step();
        rst = 1'b1;
        step();

        // reset while in WAIT, then a stale rvalid
        ex_valid = 1'b1; alu_sel = INST_LD; exu_res = 64'h8000_0080; mem_rdata = RD_PAT;
        step();
        ex_valid = 1'b0;
        @(negedge clk);
        chk("rwait_req", 64'(mem_req), 64'd1);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        @(negedge clk);
        chk("rwait_in_wait_req",   64'(mem_req),  64'd0);
        chk("rwait_in_wait_ready", 64'(ls_ready), 64'd0);
        rst = 1'b0;
        #1;
        chk("rwait_rst_ready", 64'(ls_ready), 64'd1);
        chk("rwait_rst_req",   64'(mem_req),  64'd0);
        step(); step();
        rst = 1'b1;
        mem_rvalid = 1'b1;
        @(negedge clk);
        chk("late_rv_valid0", 64'(ls_valid), 64'd0);
        step();
        mem_rvalid = 1'b0;
        @(negedge clk);
        chk("late_rv_valid1", 64'(ls_valid), 64'd0);
        chk("late_rv_res",    ls_res,        64'd0);
        chk("late_rv_ready",  64'(ls_ready), 64'd1);
        chk("late_rv_req",    64'(mem_req),  64'd0);

        chk("req_fields_stable", 64'(n_unstable), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/ysyx_22051013_lsu.md
# ysyx_22051013_lsu

Load/store stage of the pipelined CPU, directly downstream of the execute stage. It registers each execute result, issues at most one data-memory request per instruction over a req/gnt/rvalid handshake, aligns and extends load data, and forms the write mask and shifted data for stores. It hands a valid result to the write-back stage under valid/ready flow control.

## Interface
- No parameters. Widths come from the shared define file: DATA = 64, REG = 64, PC = 64.
- `clk` in 1: the single clock.
- `rst` in 1: asynchronous, active-low reset.
- `ex_valid` in 1: the execute stage holds a valid instruction.
- `ls_ready` out 1: this stage accepts an instruction this cycle.
- `alu_sel` in 8: instruction select code, from the shared `INST_*` codes.
- `exu_res` in 64: for loads and stores this is the effective address; otherwise it is the result.
- `store_data` in 64: store operand (unshifted).
- `rd_addr` in 5: destination register, passed through.
- `rd_wen` in 1: destination register write enable, passed through.
- `wb_ready` in 1: the write-back stage accepts.
- `ls_valid` out 1: the result is valid for write-back.
- `ls_res` out 64: write-back data.
- `ls_rd_addr` out 5: registered `rd_addr`.
- `ls_rd_wen` out 1: registered `rd_wen`, forced to 0 on a misaligned access.
- `ls_misalign` out 1: the current result came from a misaligned access.
- `mem_req` out 1: memory request.
- `mem_we` out 1: 1 means store.
- `mem_addr` out 64: request address, `{addr[63:3], 3'b0}`.
- `mem_wdata` out 64: store data shifted to its lane.
- `mem_wmask` out 8: byte write mask.
- `mem_gnt` in 1: the request is taken.
- `mem_rvalid` in 1: load data is returned.
- `mem_rdata` in 64: load data, a full aligned doubleword.

## Operation
- States: `IDLE`, `REQ`, `WAIT`, `DONE`.
- Accept condition: `ex_valid && ls_ready`. On accept, register `alu_sel`, `exu_res`, `store_data`, `rd_addr` and `rd_wen`.
- `ls_ready = (state==IDLE) || (state==DONE && wb_ready)`. This allows back-to-back operation.
- On accept, the next state depends on the instruction:
  - Non-memory op: go to `DONE` with `ls_res = exu_res`.
  - Aligned load or store: go to `REQ`.
  - Misaligned load or store: go to `DONE` with `ls_res = 0`, `ls_misalign = 1`, `ls_rd_wen = 0`. No request is issued.
- Alignment rules, with `off = addr[2:0]`:
  - Halfword access needs `off[0] == 0`.
  - Word access needs `off[1:0] == 0`.
  - Doubleword access needs `off == 0`.
- `REQ` state:
  - `mem_req = 1`. The request fields stay stable until `mem_gnt`.
  - On `mem_gnt`, a store goes to `DONE` and a load goes to `WAIT`.
- `WAIT` state:
  - On `mem_rvalid`, latch the extended data into `ls_res` and go to `DONE`.
- `DONE` state:
  - `ls_valid = 1`, with all outputs stable.
  - On `wb_ready`, go to `IDLE`, or stay in `DONE` with a new instruction if one is accepted in the same cycle. Accepting a memory op from `DONE` goes to `REQ`.
- Store forming:
  - `mem_wdata = store_data << (8*off)`.
  - `mem_wmask` is `8'h01 << off` for SB, `8'h03 << off` for SH, `8'h0F << off` for SW, and `8'hFF` for SD.
  - For loads, `mem_wmask = 0`.
- Load extension:
  - Select the byte, half or word at `off` within `mem_rdata`.
  - LB, LH and LW sign-extend to 64 bits.
  - LBU, LHU and LWU zero-extend.
  - LD takes all 64 bits.
- A store's `ls_res` is `exu_res` and `rd_wen` passes through unchanged.
- `mem_rvalid` is ignored in every state except `WAIT`. `mem_gnt` is ignored when `mem_req == 0`.

## Timing
- Reset values: state `IDLE`, `ls_valid` 0, `ls_res` 0, `ls_rd_addr` 0, `ls_rd_wen` 0, `ls_misalign` 0, `mem_req` 0, `mem_we` 0, `mem_addr` 0, `mem_wdata` 0, `mem_wmask` 0. `ls_ready` is 1.
- Reset mid-transaction drops `mem_req` immediately. A late `rvalid` after reset is discarded.
- All memory outputs are registered or decoded from the state plus registered fields. There is no combinational path from any `mem_*` input to `mem_req`.
- Latency from the accept edge at cycle N:
  - Non-memory op or misaligned op: `ls_valid` at N+1.
  - Store with `gnt` in its first `REQ` cycle: `ls_valid` at N+2.
  - Load with `gnt` at N+1 and `rvalid` at N+2: `ls_valid` at N+3.
- Each cycle of `gnt` or `rvalid` delay adds one cycle. Each `wb_ready = 0` cycle holds `DONE`.
- Throughput for non-memory ops is one per cycle when `wb_ready` is held at 1.

## Structure
- The `INST_*` select codes and data-width macros belong in the shared define file.
- The state encoding is a localparam inside the module.
- One combinational sub-module, `ysyx_22051013_lsu_align`, computes from `alu_sel`, `off`, `store_data` and `mem_rdata`:
  - `is_load`, `is_store`, `misalign`
  - `wmask`, `wdata`
  - the extended load data
- The top module holds the FSM and the output registers.

## Test plan
- ADD result `64'h1234` with `wb_ready = 1` → `ls_valid` one cycle later with `ls_res = 64'h1234`. Two consecutive non-memory ops complete in consecutive cycles.
- SB at address `0x8000_0005` with `store_data = 64'hAB` → `mem_addr = 0x8000_0000`, `mem_wmask = 8'h20`, `mem_wdata = 64'h0000_AB00_0000_0000`, `mem_we = 1`.
- LB at offset 3 with `mem_rdata = 64'h0000_0000_8000_0000`, then repeat as LBU, both with `gnt` delayed 2 cycles:
  - LB → `ls_res = 64'hFFFF_FFFF_FFFF_FF80`.
  - LBU → `ls_res = 64'h80`.
  - `mem_req` holds for 3 cycles.
- LW at offset 2 → no `mem_req`, `ls_misalign = 1`, `ls_rd_wen = 0`, `ls_res = 0` one cycle after accept.
- LD with `wb_ready = 0` for 4 cycles after `rvalid` → `ls_valid` and `ls_res` stay stable and `ls_ready = 0` until `wb_ready` rises.
- Assert `rst = 0` during `WAIT`, then pulse `mem_rvalid` after release → `mem_req = 0`, state `IDLE`, `ls_valid` stays 0.
